// File: rtl/id_exe_stage_reg_pkg.sv
// Shared pipeline constants: control-bundle width, field positions and the
// bubble encoding reused by every stage register.
package id_exe_stage_reg_pkg;

    localparam int CTRL_W = 16;

    localparam int CTRL_REGWRITE      = 0;
    localparam int CTRL_ALUSRC        = 1;
    localparam int CTRL_MEMWRITE      = 2;
    localparam int CTRL_MEMREAD       = 3;
    localparam int CTRL_MEMTYPE_LSB   = 4;
    localparam int CTRL_MEMTYPE_W     = 2;
    localparam int CTRL_RESULTSRC_LSB = 6;
    localparam int CTRL_RESULTSRC_W   = 2;
    localparam int CTRL_ALUOP_LSB     = 8;
    localparam int CTRL_ALUOP_W       = 3;
    localparam int CTRL_BEQ           = 11;
    localparam int CTRL_BNE           = 12;
    localparam int CTRL_JAL           = 13;
    localparam int CTRL_JALR          = 14;
    localparam int CTRL_SPARE         = 15;

    // All-zero bundle: no register, memory or branch side effects.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// Decode/execute side bundle of the ID->EXE stage register.
interface id_exe_stage_reg_if #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = id_exe_stage_reg_pkg::CTRL_W,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_rs1;
    logic [XLEN-1:0]   in_rs2;
    logic [XLEN-1:0]   in_imm;
    logic [REG_W-1:0]  in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_rs1;
    logic [XLEN-1:0]   out_rs2;
    logic [XLEN-1:0]   out_imm;
    logic [REG_W-1:0]  out_rd;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, in_valid, in_ctrl, in_pc, in_rs1, in_rs2, in_imm, in_rd, out_ready,
        input  in_ready, out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_imm, out_rd,
               stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_pc, in_rs1, in_rs2, in_imm, in_rd, out_ready,
        output in_ready, out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_imm, out_rd,
               stall_cnt
    );
endinterface

// File: rtl/id_exe_stage_reg_skid_buf.sv
// Generic two-entry valid/ready buffer: a main entry driving the outputs and a
// skid entry that absorbs the one beat in flight when the consumer stalls.
module stage_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    logic              main_vld_p1;
    logic              skid_vld_p1;
    logic [DATA_W-1:0] main_data_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic              in_fire;
    logic              main_load;

    // Ready comes only from the skid flag, so there is no path from in_valid or out_ready.
    assign in_ready  = !skid_vld_p1 && !reset;
    assign in_fire   = in_valid && in_ready;
    assign main_load = !main_vld_p1 || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld_p1  <= 1'b0;
            skid_vld_p1  <= 1'b0;
            main_data_p1 <= '0;
            skid_data_p1 <= '0;
        end else if (flush) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (main_load) begin
            if (skid_vld_p1) begin
                main_data_p1 <= skid_data_p1;
                main_vld_p1  <= 1'b1;
                skid_vld_p1  <= 1'b0;
            end else if (in_fire) begin
                main_data_p1 <= in_data;
                main_vld_p1  <= 1'b1;
            end else begin
                main_vld_p1 <= 1'b0;
            end
        end else if (in_fire) begin
            skid_data_p1 <= in_data;
            skid_vld_p1  <= 1'b1;
        end
    end

    assign out_valid = main_vld_p1;
    assign out_data  = main_data_p1;
endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE stage register: skid-buffered handshake, bubble clearing on empty or
// squashed slots, and a stall-cycle counter.
module id_exe_stage_reg #(
    parameter int XLEN       = 64,
    parameter int CTRL_W     = id_exe_stage_reg_pkg::CTRL_W,
    parameter int REG_W      = 5,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = 32
) (
    input logic               clk,
    input logic               reset,
    id_exe_stage_reg_if.slave bus
);
    import id_exe_stage_reg_pkg::*;

    localparam int PAY_W    = CTRL_W + 4 * XLEN + REG_W;
    localparam bit CLEAR_EN = (CLEAR_DATA != 0);

    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  main_pay_p1;
    logic              main_vld_p1;
    logic [CTRL_W-1:0] main_ctrl;
    logic [XLEN-1:0]   main_pc;
    logic [XLEN-1:0]   main_rs1;
    logic [XLEN-1:0]   main_rs2;
    logic [XLEN-1:0]   main_imm;
    logic [REG_W-1:0]  main_rd;
    logic              zero_data;
    logic [CNT_W-1:0]  stall_cnt_p1;

    assign in_pay = {bus.in_ctrl, bus.in_pc, bus.in_rs1, bus.in_rs2, bus.in_imm, bus.in_rd};

    // ---- p0 -> p1: decode beat captured into main/skid ----
    stage_skid_buf #(.DATA_W(PAY_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_pay),
        .out_valid (main_vld_p1),
        .out_ready (bus.out_ready),
        .out_data  (main_pay_p1)
    );

    assign {main_ctrl, main_pc, main_rs1, main_rs2, main_imm, main_rd} = main_pay_p1;
    assign zero_data = CLEAR_EN && !main_vld_p1;

    assign bus.out_valid = main_vld_p1;
    assign bus.out_ctrl  = main_vld_p1 ? main_ctrl : CTRL_W'(CTRL_BUBBLE);
    assign bus.out_pc    = zero_data ? '0 : main_pc;
    assign bus.out_rs1   = zero_data ? '0 : main_rs1;
    assign bus.out_rs2   = zero_data ? '0 : main_rs2;
    assign bus.out_imm   = zero_data ? '0 : main_imm;
    assign bus.out_rd    = zero_data ? '0 : main_rd;

    // ---- p1: stall accounting, survives flush ----
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_p1 <= '0;
        end else if (main_vld_p1 && !bus.out_ready) begin
            stall_cnt_p1 <= stall_cnt_p1 + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_p1;
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Bench for id_exe_stage_reg: three instances (hold data, clear data, 4-bit
// counter) share stimulus and are compared against a two-deep FIFO model.
module tb_id_exe_stage_reg;
    import id_exe_stage_reg_pkg::*;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   imm;
        logic [REG_W-1:0]  rd;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic              t_flush, t_iv, t_ordy;
    logic [CTRL_W-1:0] t_ctrl;
    logic [XLEN-1:0]   t_pc, t_rs1, t_rs2, t_imm;
    logic [REG_W-1:0]  t_rd;

    id_exe_stage_reg_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .REG_W(REG_W), .CNT_W(32)) b0 ();
    id_exe_stage_reg_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .REG_W(REG_W), .CNT_W(32)) b1 ();
    id_exe_stage_reg_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .REG_W(REG_W), .CNT_W(4))  b2 ();

    assign b0.flush = t_flush; assign b0.in_valid = t_iv; assign b0.out_ready = t_ordy;
    assign b0.in_ctrl = t_ctrl; assign b0.in_pc = t_pc; assign b0.in_rs1 = t_rs1;
    assign b0.in_rs2 = t_rs2; assign b0.in_imm = t_imm; assign b0.in_rd = t_rd;
    assign b1.flush = t_flush; assign b1.in_valid = t_iv; assign b1.out_ready = t_ordy;
    assign b1.in_ctrl = t_ctrl; assign b1.in_pc = t_pc; assign b1.in_rs1 = t_rs1;
    assign b1.in_rs2 = t_rs2; assign b1.in_imm = t_imm; assign b1.in_rd = t_rd;
    assign b2.flush = t_flush; assign b2.in_valid = t_iv; assign b2.out_ready = t_ordy;
    assign b2.in_ctrl = t_ctrl; assign b2.in_pc = t_pc; assign b2.in_rs1 = t_rs1;
    assign b2.in_rs2 = t_rs2; assign b2.in_imm = t_imm; assign b2.in_rd = t_rd;

    id_exe_stage_reg #(.XLEN(XLEN), .REG_W(REG_W), .CLEAR_DATA(0), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    id_exe_stage_reg #(.XLEN(XLEN), .REG_W(REG_W), .CLEAR_DATA(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));
    id_exe_stage_reg #(.XLEN(XLEN), .REG_W(REG_W), .CLEAR_DATA(0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .bus(b2.slave));

    ent_t o0, o1, o2;
    assign o0 = {b0.out_ctrl, b0.out_pc, b0.out_rs1, b0.out_rs2, b0.out_imm, b0.out_rd};
    assign o1 = {b1.out_ctrl, b1.out_pc, b1.out_rs1, b1.out_rs2, b1.out_imm, b1.out_rd};
    assign o2 = {b2.out_ctrl, b2.out_pc, b2.out_rs1, b2.out_rs2, b2.out_imm, b2.out_rd};

    int n_vec = 0;
    int n_mis = 0;

    // Reference: the stage behaves as a FIFO of depth two whose head is the output.
    ent_t        mq[$];
    ent_t        src_q[$];
    ent_t        last_shown;
    logic [31:0] mcnt;
    bit          d_reset, d_flush, d_ordy, d_ivgate, chk_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CTRL_W-1:0] rand_ctrl();
        logic [CTRL_W-1:0] c;
        c = '0;
        c[CTRL_REGWRITE] = 1'($urandom);
        c[CTRL_ALUSRC]   = 1'($urandom);
        c[CTRL_MEMWRITE] = 1'($urandom);
        c[CTRL_MEMREAD]  = 1'($urandom);
        c[CTRL_MEMTYPE_LSB +: CTRL_MEMTYPE_W]     = CTRL_MEMTYPE_W'($urandom);
        c[CTRL_RESULTSRC_LSB +: CTRL_RESULTSRC_W] = CTRL_RESULTSRC_W'($urandom);
        c[CTRL_ALUOP_LSB +: CTRL_ALUOP_W]         = CTRL_ALUOP_W'($urandom);
        c[CTRL_BEQ]   = 1'($urandom);
        c[CTRL_BNE]   = 1'($urandom);
        c[CTRL_JAL]   = 1'($urandom);
        c[CTRL_JALR]  = 1'($urandom);
        c[CTRL_SPARE] = 1'b1;
        return c;
    endfunction

    function automatic ent_t mk(input logic [XLEN-1:0] pc, input logic [CTRL_W-1:0] ctrl);
        ent_t e;
        e.ctrl = ctrl;
        e.pc   = pc;
        e.rs1  = {$urandom, $urandom};
        e.rs2  = {$urandom, $urandom};
        e.imm  = {$urandom, $urandom};
        e.rd   = REG_W'($urandom);
        return e;
    endfunction

    task automatic check_dut(input string nm, input ent_t o, input logic vld, input logic rdy,
                             input logic [31:0] cnt, input bit clear, input logic [31:0] cmask,
                             input bit exp_rdy);
        ent_t e;
        if (mq.size() > 0) e = mq[0];
        else begin
            e = clear ? '0 : last_shown;
            e.ctrl = '0;
        end
        chk({nm, ".in_ready"},  64'(rdy), 64'(exp_rdy));
        chk({nm, ".out_valid"}, 64'(vld), 64'(mq.size() > 0));
        chk({nm, ".out_ctrl"},  64'(o.ctrl), 64'(e.ctrl));
        chk({nm, ".out_pc"},    o.pc,  e.pc);
        chk({nm, ".out_rs1"},   o.rs1, e.rs1);
        chk({nm, ".out_rs2"},   o.rs2, e.rs2);
        chk({nm, ".out_imm"},   o.imm, e.imm);
        chk({nm, ".out_rd"},    64'(o.rd), 64'(e.rd));
        chk({nm, ".stall_cnt"}, 64'(cnt), 64'(mcnt & cmask));
    endtask

    task automatic tick();
        ent_t cur;
        bit   iv, exp_v, exp_rdy, fire;
        @(negedge clk);
        iv  = d_ivgate && (src_q.size() > 0);
        cur = iv ? src_q[0] : ent_t'(0);
        reset = d_reset; t_flush = d_flush; t_ordy = d_ordy; t_iv = iv;
        t_ctrl = cur.ctrl; t_pc = cur.pc; t_rs1 = cur.rs1; t_rs2 = cur.rs2;
        t_imm = cur.imm; t_rd = cur.rd;
        #1;
        exp_v   = mq.size() > 0;
        exp_rdy = !d_reset && (mq.size() < 2);
        if (chk_en) begin
            check_dut("d0", o0, b0.out_valid, b0.in_ready, b0.stall_cnt, 1'b0, 32'hFFFF_FFFF, exp_rdy);
            check_dut("d1", o1, b1.out_valid, b1.in_ready, b1.stall_cnt, 1'b1, 32'hFFFF_FFFF, exp_rdy);
            check_dut("d2", o2, b2.out_valid, b2.in_ready, 32'(b2.stall_cnt), 1'b0, 32'hF, exp_rdy);
        end
        fire = iv && exp_rdy;
        if (d_reset) begin
            mq.delete();
            last_shown = '0;
            mcnt = '0;
        end else begin
            if (exp_v && !d_ordy) mcnt = mcnt + 1;
            if (d_flush) mq.delete();
            else begin
                if (exp_v && d_ordy) void'(mq.pop_front());
                if (fire) mq.push_back(cur);
                if (mq.size() > 0) last_shown = mq[0];
            end
        end
        if (fire) void'(src_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    ent_t ed;

    initial begin
        reset = 1'b1; t_flush = 0; t_iv = 0; t_ordy = 0;
        t_ctrl = '0; t_pc = '0; t_rs1 = '0; t_rs2 = '0; t_imm = '0; t_rd = '0;
        last_shown = '0; mcnt = '0;
        d_reset = 1; d_flush = 0; d_ordy = 0; d_ivgate = 1; chk_en = 0;
        tick();
        chk_en = 1;
        tick();
        d_reset = 0;

        // Streaming at full rate.
        d_ordy = 1;
        src_q.push_back(mk(64'h0, rand_ctrl()));
        src_q.push_back(mk(64'h4, rand_ctrl()));
        src_q.push_back(mk(64'h8, rand_ctrl()));
        run(5);
        chk("A.stall_cnt", 64'(b0.stall_cnt), 64'd0);

        // Back-pressure fills main and skid, third beat waits in decode.
        d_ordy = 0;
        src_q.push_back(mk(64'h10, rand_ctrl()));
        src_q.push_back(mk(64'h14, rand_ctrl()));
        src_q.push_back(mk(64'h18, rand_ctrl()));
        run(4);
        chk("B.in_ready", 64'(b0.in_ready), 64'd0);
        chk("B.out_pc", b0.out_pc, 64'h10);
        chk("B.stall_cnt", 64'(b0.stall_cnt), 64'd3);
        d_ordy = 1;
        run(5);

        // Flush with both entries holding a full control bundle.
        d_ordy = 0;
        src_q.push_back(mk(64'h30, '1));
        src_q.push_back(mk(64'h34, '1));
        run(3);
        src_q.push_back(mk(64'h38, '1));
        d_flush = 1;
        tick();
        d_flush = 0;
        chk("C.out_valid", 64'(b0.out_valid), 64'd0);
        chk("C.out_ctrl", 64'(b0.out_ctrl), 64'd0);
        chk("C.in_ready", 64'(b0.in_ready), 64'd1);
        tick();
        src_q.push_back(mk(64'h3C, '1));
        d_flush = 1;
        tick();
        d_flush = 0;
        d_ivgate = 0;
        tick();
        chk("C.dropped", 64'(b0.out_valid), 64'd0);
        src_q.delete();
        d_ivgate = 1;

        // Single beat then idle: bubble data clearing vs holding.
        d_ordy = 1;
        ed = mk(64'h20, rand_ctrl());
        src_q.push_back(ed);
        run(2);
        chk("D.clr_pc", b1.out_pc, 64'd0);
        chk("D.clr_rs1", b1.out_rs1, 64'd0);
        chk("D.clr_imm", b1.out_imm, 64'd0);
        chk("D.hold_pc", b0.out_pc, 64'h20);
        chk("D.hold_rs1", b0.out_rs1, ed.rs1);
        chk("D.hold_ctrl", 64'(b0.out_ctrl), 64'd0);

        // Reset in the middle of a stall with skid full.
        d_ordy = 0;
        src_q.push_back(mk(64'h40, rand_ctrl()));
        src_q.push_back(mk(64'h44, rand_ctrl()));
        src_q.push_back(mk(64'h48, rand_ctrl()));
        run(5);
        d_reset = 1;
        tick();
        src_q.delete();
        chk("E.out_valid", 64'(b0.out_valid), 64'd0);
        chk("E.out_pc", b0.out_pc, 64'd0);
        chk("E.stall_cnt", 64'(b0.stall_cnt), 64'd0);
        chk("E.in_ready_rst", 64'(b0.in_ready), 64'd0);
        d_reset = 0;
        tick();
        chk("E.in_ready", 64'(b0.in_ready), 64'd1);

        // Counter wrap on the 4-bit instance: 17 stalled cycles.
        d_reset = 1;
        tick();
        d_reset = 0;
        src_q.push_back(mk(64'h50, rand_ctrl()));
        run(18);
        chk("F.wrap", 64'(b2.stall_cnt), 64'd1);
        chk("F.nowrap", 64'(b0.stall_cnt), 64'd17);

        // Randomized traffic.
        d_ordy = 1;
        for (int i = 0; i < 800; i++) begin
            if (src_q.size() < 2 && $urandom_range(0, 2) != 0)
                src_q.push_back(mk(64'($urandom), rand_ctrl()));
            d_ivgate = $urandom_range(0, 4) != 0;
            if ($urandom_range(0, 7) == 0) d_ordy = !d_ordy;
            d_flush = $urandom_range(0, 24) == 0;
            d_reset = $urandom_range(0, 79) == 0;
            tick();
        end
        d_flush = 0; d_reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
